// File: rtl/parity_fifo_top.sv
// rtl/parity_fifo_top.sv - parity-screened synchronous FIFO with valid/grant handshakes
// PARITY_CHECK_EN: when defined, granted words with bad parity are consumed but dropped.
package types_pkg;
  typedef enum logic {ODD, EVEN} parity_mode_e;
  typedef enum logic {MSB, LSB} parity_bit_e;
endpackage

module parity_fifo_top #(
  parameter int                      DATA_WIDTH        = 10,
  parameter int                      DEPTH             = 12,
  parameter types_pkg::parity_mode_e PARITY_MODE       = types_pkg::ODD,
  parameter types_pkg::parity_bit_e  PARITY_BIT_CHOICE = types_pkg::MSB
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_valid_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  push_grant_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  grant_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic                  full;
  logic                  empty;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  store;

  logic [DATA_WIDTH-2:0] rest_bits;
  logic                  par_bit;
  logic                  expected_bit;
  logic                  parity_ok;

  // Split the incoming word into its parity bit and the bits it covers.
  always_comb begin
    par_bit   = push_data_i[DATA_WIDTH-1];
    rest_bits = push_data_i[DATA_WIDTH-2:0];
    if (PARITY_BIT_CHOICE == types_pkg::LSB) begin
      par_bit   = push_data_i[0];
      rest_bits = push_data_i[DATA_WIDTH-1:1];
    end
  end

  assign expected_bit = (PARITY_MODE == types_pkg::ODD) ? ~^rest_bits : ^rest_bits;
  assign parity_ok    = (par_bit == expected_bit);

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign push_grant_o = reset_n & ~full;
  assign valid_o      = ~empty;
  assign data_o       = empty ? '0 : mem[rd_ptr];

  assign push_fire = push_valid_i & push_grant_o;
  assign pop_fire  = valid_o & grant_i;

`ifdef PARITY_CHECK_EN
  assign store = push_fire & parity_ok;
`else
  logic unused_parity_ok;
  assign unused_parity_ok = parity_ok;
  assign store = push_fire;
`endif

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (store) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
    end else if (pop_fire) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    end
  end

  // A simultaneous store and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({store, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_fifo_top.sv
// tb/tb_parity_fifo_top.sv - directed self-checking bench for parity_fifo_top
module tb_parity_fifo_top;

  logic       clk;
  logic       reset_n;
  logic       push_valid_i;
  logic [9:0] push_data_i;
  logic       push_grant_o;
  logic       valid_o;
  logic [9:0] data_o;
  logic       grant_i;

  int checks;
  int failures;

  parity_fifo_top #(
    .DATA_WIDTH(10),
    .DEPTH(12),
    .PARITY_MODE(types_pkg::ODD),
    .PARITY_BIT_CHOICE(types_pkg::MSB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .push_valid_i(push_valid_i),
    .push_data_i(push_data_i),
    .push_grant_o(push_grant_o),
    .valid_o(valid_o),
    .data_o(data_o),
    .grant_i(grant_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Odd-parity word: MSB set so the total count of ones is odd.
  function automatic logic [9:0] mk(input logic [8:0] v);
    return {~^v, v};
  endfunction

  initial begin
    logic [9:0] exp_q[$];
    int         pushed;
    logic [9:0] w;

    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    push_valid_i = 1'b0;
    push_data_i = '0;
    grant_i = 1'b0;

    // 1. reset and idle
    tick();
    tick();
    check("rst_grant", push_grant_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    reset_n = 1'b1;
    tick();
    check("idle_grant", push_grant_o, 1);
    check("idle_valid", valid_o, 0);
    check("idle_data", data_o, 0);

    // 2. single push then pop
    push_valid_i = 1'b1;
    push_data_i = 10'b1000000000;
    tick();
    push_valid_i = 1'b0;
    check("t2_valid", valid_o, 1);
    check("t2_data", data_o, 10'b1000000000);
    tick();
    check("t2_hold", data_o, 10'b1000000000);
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    check("t2_empty", valid_o, 0);
    check("t2_zero", data_o, 0);

    // 3. fill to full, 13th push held off, drain in order
    for (int i = 0; i < 12; i++) begin
      check("t3_fill_grant", push_grant_o, 1);
      push_valid_i = 1'b1;
      push_data_i = mk(9'(i + 1));
      tick();
    end
    push_valid_i = 1'b0;
    check("t3_full_grant", push_grant_o, 0);
    push_valid_i = 1'b1;
    push_data_i = mk(9'd100);
    tick();
    push_valid_i = 1'b0;
    check("t3_held_grant", push_grant_o, 0);
    check("t3_head", data_o, mk(9'd1));
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    check("t3_regrant", push_grant_o, 1);
    for (int i = 1; i < 12; i++) begin
      check("t3_order", data_o, mk(9'(i + 1)));
      grant_i = 1'b1;
      tick();
    end
    grant_i = 1'b0;
    check("t3_drained", valid_o, 0);

    // 5. full with push and pop in the same edge
    for (int i = 0; i < 12; i++) begin
      push_valid_i = 1'b1;
      push_data_i = mk(9'(20 + i));
      tick();
    end
    check("t5_full", push_grant_o, 0);
    push_data_i = mk(9'd50);
    grant_i = 1'b1;
    check("t5_head", data_o, mk(9'd20));
    tick();
    grant_i = 1'b0;
    check("t5_after_pop_grant", push_grant_o, 1);
    check("t5_after_pop_head", data_o, mk(9'd21));
    tick();
    push_valid_i = 1'b0;
    check("t5_refull", push_grant_o, 0);
    for (int i = 0; i < 12; i++) begin
      check("t5_order", data_o, (i < 11) ? mk(9'(21 + i)) : mk(9'd50));
      grant_i = 1'b1;
      tick();
    end
    grant_i = 1'b0;
    check("t5_drained", valid_o, 0);

    // 4. streaming push and pop across pointer wrap
    pushed = 0;
    for (int cyc = 0; cyc < 200 && (pushed < 30 || exp_q.size() != 0); cyc++) begin
      push_valid_i = (pushed < 30);
      push_data_i = mk(9'((pushed * 37 + 5) & 9'h1ff));
      grant_i = 1'b1;
      check("t4_valid", valid_o, (exp_q.size() != 0));
      check("t4_grant", push_grant_o, (exp_q.size() < 12));
      if (valid_o && grant_i && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("t4_data", data_o, w);
      end
      if (push_valid_i && push_grant_o) begin
        exp_q.push_back(push_data_i);
        pushed++;
      end
      tick();
    end
    push_valid_i = 1'b0;
    grant_i = 1'b0;
    check("t4_done", (pushed == 30 && exp_q.size() == 0), 1);
    check("t4_empty", valid_o, 0);

    // 6. parity screening
    push_valid_i = 1'b1;
    push_data_i = 10'b0000000011;
    check("t6_grant_even", push_grant_o, 1);
    tick();
    push_data_i = 10'b0000000111;
    check("t6_grant_odd", push_grant_o, 1);
    tick();
    push_valid_i = 1'b0;
`ifdef PARITY_CHECK_EN
    check("t6_chk_valid", valid_o, 1);
    check("t6_chk_data", data_o, 10'b0000000111);
    grant_i = 1'b1;
    tick();
    grant_i = 1'b0;
    check("t6_chk_empty", valid_o, 0);
`else
    check("t6_first", data_o, 10'b0000000011);
    grant_i = 1'b1;
    tick();
    check("t6_second", data_o, 10'b0000000111);
    tick();
    grant_i = 1'b0;
    check("t6_empty", valid_o, 0);
`endif

    // asynchronous reset mid-operation
    push_valid_i = 1'b1;
    push_data_i = mk(9'd7);
    tick();
    push_valid_i = 1'b0;
    check("ar_pre_valid", valid_o, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", valid_o, 0);
    check("ar_grant", push_grant_o, 0);
    check("ar_data", data_o, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("ar_rel_grant", push_grant_o, 1);
    check("ar_rel_valid", valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
